// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry process the operands LSB first.
// Operands are captured on an accepted start; the parallel result appears with a one-cycle done.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ra_q, rb_q, rs_q, sum_q;
  logic [CntW-1:0]  count_q;
  logic             carry_q, cout_q, busy_q, done_q;

  logic             s_bit, carry_d;
  logic [WIDTH-1:0] rs_d;

  always_comb begin
    s_bit   = ra_q[0] ^ rb_q[0] ^ carry_q;
    carry_d = (ra_q[0] & rb_q[0]) | (rb_q[0] & carry_q) | (carry_q & ra_q[0]);
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    rs_d            = rs_q >> 1;
    rs_d[WIDTH-1]   = s_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            carry_q <= cin;
            rs_q    <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          ra_q    <= ra_q >> 1;
          rb_q    <= rb_q >> 1;
          rs_q    <= rs_d;
          carry_q <= carry_d;
          count_q <= count_q + 1'b1;
          if (count_q == LastBit) begin
            sum_q   <= rs_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance driven from a vector table plus corner
// sequences, and a 1-bit instance swept over all input combinations.
module tb_serial_adder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, cin1, cout1, busy1, done1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  int n_pass = 0;
  int n_total = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy1 && done1)) overlap++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  // Runs one addition on the 8-bit instance; scrambles the inputs after acceptance.
  task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec, input string nm);
    int  bcnt;
    bit  got;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
    bcnt = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done8) got = 1'b1;
      else begin
        if (busy8) bcnt++;
        @(negedge clk);
      end
    end
    check({nm, " done_seen"}, 32'(got), 32'd1);
    check({nm, " busy_cycles"}, bcnt, 8);
    check({nm, " sum"}, 32'(sum8), 32'(es));
    check({nm, " cout"}, 32'(cout8), 32'(ec));
  endtask

  vec_t vecs[5];
  int   dcnt, first_d, last_d, bad_spacing;
  logic [7:0] s_before;

  initial begin
    vecs[0] = '{a: 8'h3C, b: 8'h5A, cin: 1'b0, sum: 8'h96, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
    vecs[4] = '{a: 8'hA5, b: 8'h6E, cin: 1'b1, sum: 8'h14, cout: 1'b1};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;
    check("reset sum", 32'(sum8), 0);
    check("reset cout", 32'(cout8), 0);
    check("reset busy", 32'(busy8), 0);
    check("reset done", 32'(done8), 0);
    check("reset w1 outputs", 32'({sum1, cout1, busy1, done1}), 0);

    for (int i = 0; i < 5; i++)
      add8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

    // Start pulse and input changes mid-SHIFT must be ignored.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h77;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin
        dcnt++;
        check("midstart sum", 32'(sum8), 32'h96);
        check("midstart cout", 32'(cout8), 0);
      end
      @(negedge clk);
    end
    check("midstart done_count", dcnt, 1);

    // Reset in the 4th SHIFT cycle abandons the operation.
    a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 32'(busy8), 1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort busy", 32'(busy8), 0);
    check("abort done", 32'(done8), 0);
    check("abort sum", 32'(sum8), 0);
    check("abort cout", 32'(cout8), 0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) dcnt++;
      @(negedge clk);
    end
    check("abort no activity", dcnt, 0);
    add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post-abort");

    // Start held high: one result every WIDTH+2 cycles.
    @(negedge clk);
    s_before = sum8;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    dcnt = 0; first_d = -1; last_d = -1; bad_spacing = 0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        if (sum8 !== s_before) bad_spacing++;
      end
      if (done8) begin
        if (last_d >= 0 && cyc - last_d != 10) bad_spacing++;
        if (first_d < 0) first_d = cyc;
        last_d = cyc;
        dcnt++;
        check("held sum", 32'(sum8), 0);
        check("held cout", 32'(cout8), 1);
      end
    end
    start8 = 1'b0;
    check("held done_count", dcnt, 3);
    check("held first_done", first_d, 8);
    check("held spacing", bad_spacing, 0);

    // WIDTH=1: all eight input combinations.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp;
      v = 3'(i);
      exp = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      @(negedge clk);
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = ~v[0]; b1 = ~v[1]; cin1 = ~v[2];
      check($sformatf("w1 c%0d busy", i), 32'({busy1, done1}), 32'b10);
      @(negedge clk);
      check($sformatf("w1 c%0d done", i), 32'({busy1, done1}), 32'b01);
      check($sformatf("w1 c%0d result", i), 32'({cout1, sum1}), 32'(exp));
    end

    check("busy/done overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It computes a + b + cin one bit per clock, LSB first, using one full-adder cell and a registered carry.
- It is the additive counterpart to our full-subtractor cells: sum bit = a^b^c, carry = a&b | b&c | c&a.
- Operands are captured in parallel on a start/done handshake. The result is presented in parallel.
- Used where area matters more than latency: datapath helpers and checksum accumulation.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- sum  output  WIDTH  registered result; stable except on entry to DONE
- cout  output  1  registered carry-out of the MSB
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse: sum/cout just updated

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE; sum=0, cout=0, busy=0, done=0.
  - Internal shift registers, bit counter and carry register cleared.
  - Reset has priority over every other input, including mid-SHIFT: the operation in flight is abandoned and no done is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load a→ra, b→rb, cin→carry, count=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), at each edge:
  - s = ra[0]^rb[0]^carry.
  - carry <= ra[0]&rb[0] | rb[0]&carry | carry&ra[0].
  - ra, rb shift right by 1 (zero-fill).
  - s shifts into the MSB of internal register rs (rs shifts right).
  - count increments.
- On the edge that processes bit WIDTH-1 (count==WIDTH-1):
  - sum <= final rs, i.e. {s, rs[WIDTH-1:1]}.
  - cout <= new carry.
  - go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queueing: a start pulse during those states is lost.
- Latency: start accepted at edge E0; busy=1 from E0 through E_WIDTH; done=1 in the cycle after E_WIDTH. The earliest next accepted start is at edge E_(WIDTH+2). Back-to-back throughput is one result per WIDTH+2 cycles.
- sum/cout hold their last value from DONE until the next DONE. They are unchanged by a new start and unchanged by an aborted operation; only reset clears them.
- Changes to a, b and cin after the accepting edge have no effect on the result.
- Arithmetic is modulo 2^WIDTH for sum; cout is bit WIDTH of a+b+cin. There is no overflow flag.
- WIDTH=1: SHIFT lasts one cycle. The counter needs at least 1 bit; size it as max(1, clog2(WIDTH)).
- busy and done are never high simultaneously.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start for 1 cycle -> busy high for 8 cycles, then done pulse for 1 cycle; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple). Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- During SHIFT, pulse start with a=0x11, b=0x22 and change the a/b inputs -> result unchanged from the original operands; no extra done pulse.
- Assert rst for 1 cycle at the 4th SHIFT cycle -> busy=0, done=0, sum=0, cout=0 next cycle; no done pulse follows. A subsequent start with a=0x01, b=0x01 gives sum=0x02, cout=0.
- Hold start=1 continuously with a=0x80, b=0x80, cin=0 -> done pulses every 10 cycles; each result is sum=0x00, cout=1.
- WIDTH=1 instance, all 8 combinations of a, b, cin -> {cout,sum} equals a+b+cin. Each completes with done 2 cycles after the accepting edge.
